// File: rtl/inst_mem_loader.sv
// Program loader: turns a framed byte stream (START_ADDR, LEN, data[, CHECKSUM]) into
// single-cycle instruction-memory byte writes. Define INST_MEM_LOADER_CHECKSUM_EN for the trailing checksum byte.
module inst_mem_loader #(
    parameter int MEM_DEPTH = 24,
    parameter int ADDR_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [7:0]           i_byte,
    input  logic                 i_byte_valid,
    output logic                 o_byte_ready,
    output logic [ADDR_BITS-1:0] o_mem_address,
    output logic [7:0]           o_mem_data,
    output logic                 o_mem_cs,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        WR,
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_e;

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    localparam state_e EndState = CSUM;
`else
    localparam state_e EndState = DONE;
`endif

    state_e               state_q, state_d;
    logic [7:0]           addr_q, addr_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           sum_q, sum_d;
    logic                 error_q, error_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]           mem_data_q, mem_data_d;

    // 9-bit arithmetic so a large LEN cannot wrap past the end of the store.
    logic [8:0] frame_end;
    logic       range_fault;

    assign frame_end   = {1'b0, addr_q} + {1'b0, i_byte};
    assign range_fault = ({1'b0, addr_q} >= 9'(MEM_DEPTH)) || (frame_end > 9'(MEM_DEPTH));

    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        error_d      = error_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        o_byte_ready = 1'b0;
        o_mem_cs     = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = ADDR;
                    error_d = 1'b0;
                    sum_d   = 8'h00;
                end
            end
            ADDR: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (i_byte_valid) begin
                    addr_d  = i_byte;
                    state_d = LEN;
                end
            end
            LEN: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (i_byte_valid) begin
                    cnt_d = i_byte;
                    if (range_fault) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else if (i_byte == 8'h00) begin
                        state_d = EndState;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (i_byte_valid) begin
                    // Load the write port now so it is valid for the whole WR cycle and holds after.
                    mem_addr_d = ADDR_BITS'(addr_q);
                    mem_data_d = i_byte;
                    sum_d      = sum_q + i_byte;
                    state_d    = WR;
                end
            end
            WR: begin
                o_mem_cs = 1'b1;
                o_busy   = 1'b1;
                addr_d   = addr_q + 8'd1;
                cnt_d    = cnt_q - 8'd1;
                state_d  = (cnt_q == 8'd1) ? EndState : DATA;
            end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            CSUM: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (i_byte_valid) begin
                    if (i_byte != sum_q) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
`endif
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            error_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            error_q    <= error_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign o_mem_address = mem_addr_q;
    assign o_mem_data    = mem_data_q;
    assign o_error       = error_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: table of frames with hand-computed results,
// plus hand sequences for reset during a write and stalled streams with stray starts.
module tb_inst_mem_loader;

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       i_byte_valid = 1'b0;
    logic       o_byte_ready;
    logic [7:0] o_mem_address;
    logic [7:0] o_mem_data;
    logic       o_mem_cs;
    logic       o_busy;
    logic       o_done;
    logic       o_error;

    inst_mem_loader #(.MEM_DEPTH(24), .ADDR_BITS(8)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .o_mem_address(o_mem_address),
        .o_mem_data   (o_mem_data),
        .o_mem_cs     (o_mem_cs),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model and event counters, sampled on the falling edge.
    logic [7:0] model_mem [0:255];
    int         cs_count   = 0;
    int         done_count = 0;
    int         b2b_count  = 0;
    int         busy_done  = 0;
    logic       prev_cs    = 1'b0;

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_mem_cs) begin
                model_mem[o_mem_address] <= o_mem_data;
                cs_count <= cs_count + 1;
                if (prev_cs) b2b_count <= b2b_count + 1;
            end
            if (o_done) begin
                done_count <= done_count + 1;
                if (o_busy) busy_done <= busy_done + 1;
            end
            prev_cs <= o_mem_cs;
        end else begin
            prev_cs <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge i_clk);
        #1 i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        int n;
        repeat (gap) @(posedge i_clk);
        #1;
        i_byte       = b;
        i_byte_valid = 1'b1;
        i_start      = with_start;
        n = 0;
        while (1) begin
            @(negedge i_clk);
            if (o_byte_ready) break;
            n++;
            if (n > 20) begin
                check("byte_ready_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge i_clk);
            #1 i_start = 1'b0;
        end
        @(posedge i_clk);
        #1;
        i_byte_valid = 1'b0;
        i_start      = 1'b0;
    endtask

    typedef struct {
        logic [7:0]      addr;
        logic [7:0]      len;
        logic [3:0][7:0] data;
        int              ndata;
        bit              has_csum;
        logic [7:0]      csum;
        bit              exp_err;
        int              exp_done;
        int              exp_writes;
    } frame_t;

    function automatic frame_t mk(input logic [7:0] a, input logic [7:0] l,
                                  input logic [7:0] b0, input logic [7:0] b1,
                                  input logic [7:0] b2, input logic [7:0] b3,
                                  input int nd, input bit hc, input logic [7:0] cs,
                                  input bit err, input int done, input int wr);
        frame_t f;
        f.addr = a; f.len = l;
        f.data[0] = b0; f.data[1] = b1; f.data[2] = b2; f.data[3] = b3;
        f.ndata = nd; f.has_csum = hc & CSUM; f.csum = cs;
        f.exp_err = err; f.exp_done = done; f.exp_writes = wr;
        return f;
    endfunction

    task automatic run_frame(input frame_t f, input string tag);
        int cs0, d0;
        cs0 = cs_count;
        d0  = done_count;
        pulse_start();
        send_byte(f.addr, 0, 1'b0);
        send_byte(f.len, 0, 1'b0);
        for (int i = 0; i < f.ndata; i++) send_byte(f.data[i], 0, 1'b0);
        if (f.has_csum) send_byte(f.csum, 0, 1'b0);
        repeat (4) @(negedge i_clk);
        check({tag, "_cs_pulses"}, cs_count - cs0, f.exp_writes);
        check({tag, "_done"}, done_count - d0, f.exp_done);
        check({tag, "_error"}, o_error, f.exp_err);
        check({tag, "_busy_idle"}, o_busy, 1'b0);
        for (int i = 0; i < f.exp_writes; i++)
            check($sformatf("%s_mem%0d", tag, i), model_mem[f.addr + 8'(i)], f.data[i]);
    endtask

    frame_t frames [8];

    initial begin
        int cs0, d0;
        logic [7:0] stall_bytes [4];

        frames[0] = mk(8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 4, 1, 8'hAA, 0, 1, 4);
        frames[1] = mk(8'h14, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0);
        frames[2] = mk(8'h17, 8'h01, 8'h5A, 8'h00, 8'h00, 8'h00, 1, 1, 8'h5A, 0, 1, 1);
        frames[3] = mk(8'h18, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0);
        frames[4] = mk(8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00, 0, 1, 0);
        frames[5] = mk(8'h14, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 4, 1, 8'h0A, 0, 1, 4);
        frames[6] = mk(8'h10, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0);
        // Wrong checksum (sum is 03): writes still happen, but the frame faults.
        frames[7] = mk(8'h02, 8'h02, 8'h01, 8'h02, 8'h00, 8'h00, 2, 1, 8'h04,
                       CSUM, CSUM ? 0 : 1, 2);

        #2;
        check("rst_cs", o_mem_cs, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_error", o_error, 1'b0);
        check("rst_ready", o_byte_ready, 1'b0);
        check("rst_addr", o_mem_address, 8'h00);
        check("rst_data", o_mem_data, 8'h00);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        for (int k = 0; k < 8; k++) run_frame(frames[k], $sformatf("frame%0d", k));
        check("held_addr", o_mem_address, 8'h03);
        check("held_data", o_mem_data, 8'h02);
        check("held_cs", o_mem_cs, 1'b0);

        // Reset asserted while a write strobe is high.
        pulse_start();
        #1 check("busy_after_start", o_busy, 1'b1);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h77, 0, 1'b0);
        @(negedge i_clk);
        check("lat_cs", o_mem_cs, 1'b1);
        check("lat_addr", o_mem_address, 8'h00);
        check("lat_data", o_mem_data, 8'h77);
        #1 i_rst_n = 1'b0;
        #1;
        check("rstwr_cs", o_mem_cs, 1'b0);
        check("rstwr_busy", o_busy, 1'b0);
        check("rstwr_done", o_done, 1'b0);
        check("rstwr_error", o_error, 1'b0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        run_frame(mk(8'h03, 8'h02, 8'hC0, 8'hC1, 8'h00, 8'h00, 2, 1, 8'h81, 0, 1, 2), "after_rst");

        // Stalled stream with stray start pulses while busy.
        stall_bytes[0] = 8'hA1; stall_bytes[1] = 8'hB2;
        stall_bytes[2] = 8'hC3; stall_bytes[3] = 8'hD4;
        cs0 = cs_count;
        d0  = done_count;
        pulse_start();
        send_byte(8'h00, $urandom_range(0, 3), 1'b1);
        send_byte(8'h04, $urandom_range(0, 3), 1'b1);
        for (int i = 0; i < 4; i++) send_byte(stall_bytes[i], $urandom_range(0, 3), i[0]);
        if (CSUM) send_byte(8'hEA, $urandom_range(0, 3), 1'b1);
        repeat (5) @(negedge i_clk);
        check("stall_cs_pulses", cs_count - cs0, 4);
        check("stall_done", done_count - d0, 1);
        check("stall_error", o_error, 1'b0);
        check("stall_idle_ready", o_byte_ready, 1'b0);
        for (int i = 0; i < 4; i++)
            check($sformatf("stall_mem%0d", i), model_mem[i], stall_bytes[i]);
        check("cs_back_to_back", b2b_count, 0);
        check("busy_during_done", busy_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
